cpu_core_mc: RTL and testbench
==============================

// Module: cpu_core_mc
// PURPOSE
//  Parametrised multicycle successor of the 10-bit accumulator-less CPU top: fetch, decode, execute, writeback FSM.
//  Integrates PC, N-entry register file and ALU; fetches from an external synchronous ROM (1-cycle read latency).
//  Adds run control, halt state, signed BNE offsets, illegal-opcode detection and retire strobe.
// PARAMETERS
//  DATA_W  10  datapath and instruction width; must satisfy DATA_W >= 5 + 2*clog2(NREG)
//  ADDR_W  10  PC / instruction address width
//  NREG     4  register count, power of two >= 2; RSEL_W = clog2(NREG)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  run          in   1       level; leaves IDLE when high
//  branch       in   1       external redirect request, honoured only in FETCH
//  branch_addr  in   ADDR_W  external redirect target
//  imem_addr    out  ADDR_W  ROM address (= PC)
//  imem_rdata   in   DATA_W  ROM data, valid the cycle after imem_addr
//  pc_out       out  ADDR_W  current PC
//  alu_result   out  DATA_W  registered result of last EXEC
//  retire       out  1       1-cycle pulse in WB when instruction completes
//  halted       out  1       high in HALT state
//  illegal      out  1       sticky: reserved opcode executed
// BEHAVIOUR
//  Reset: state=IDLE, PC=0, all regs=0, IR=0, alu_result=0, retire=0, halted=0, illegal=0.
//  Fields: op=IR[DATA_W-1 -: 3], rs=IR[DATA_W-4 -: RSEL_W], rt=next RSEL_W bits, fn=IR[1:0].
//  FSM: IDLE -(run)-> FETCH -> DECODE -> EXEC -> WB -> FETCH; 4 cycles/instruction.
//   IDLE: holds while run=0. FETCH: imem_addr=PC; if branch=1, PC<=branch_addr, stay FETCH.
//   DECODE: IR<=imem_rdata. EXEC: alu_result<=f(R[rs],R[rt]).
//   WB: R[rt]<=alu_result for writing ops; PC update; retire=1. run low only takes effect in WB: WB->IDLE.
//  Ops (all arithmetic mod 2^DATA_W, PC mod 2^ADDR_W):
//   op000 fn00 add, 01 sub (rs-rt), 10 slt (signed, result 0/1), 11 nand; write rt; PC+1.
//   op001 fn00 srl rs>>R[rt][3:0] logical, 01 sll; write rt; PC+1.
//   op001 fn10 halt: no write; WB->HALT; PC unchanged. fn11 nop: PC+1.
//   op010 bne: no write; if R[rs]!=R[rt] PC<=PC+1+sext(fn) (offset -2..+1), else PC+1.
//   op011..op111 reserved: treated as nop, illegal<=1 in WB.
//  HALT: absorbing; halted=1, no fetch, ignores run and branch; only reset exits.
//  Write to rt with rs==rt: reads use pre-write values (EXEC precedes WB).
//  PC wrap: 2^ADDR_W-1 +1 -> 0; bne negative offset from 0 wraps to top.
//  Reset mid-instruction: asynchronously abandons state; no partial register write survives.
// CONFIGURATION
//  CPU_STEP_EN defined: adds input step (1 bit); FETCH stalls until step=1 sampled,
//   one instruction per step pulse; step held high = free run. branch still honoured while stalled.
//  CPU_STEP_EN undefined: no step port; FETCH never stalls.
// TESTING
//  Reset, run=0 for 5 cycles -> state IDLE, pc_out=0, all outputs 0, no retire.
//  R1=3,R2=5 (via add from preloaded ROM), ROM[0]=add rs=1 rt=2 -> after 4 cycles R2=8, retire pulse, PC=1.
//  slt R1=10'h3FF(-1), R2=1 -> R2=1; sub 2-5 -> 10'h3FD; sll 1 by 9 -> 10'h200.
//  bne R1!=R2 at PC=4, fn=2'b10 -> PC=3; equal operands -> PC=5; at PC=0 offset -2 -> PC=10'h3FF.
//  halt at PC=6 -> halted=1, PC stays 6 for 20 cycles despite run/branch toggling; reset -> IDLE, PC=0.
//  Reserved op011 -> illegal=1 sticky, regs unchanged, PC+1; branch=1 in FETCH with addr 10'h100 -> next fetch 10'h100.
//  CPU_STEP_EN: step low 10 cycles -> no retire; single step pulse -> exactly one retire.

Source files
------------

// File: rtl/cpu_core_mc.sv
// cpu_core_mc -- multicycle FETCH/DECODE/EXEC/WB CPU core.
//
// Purpose:
//   Integrates the PC, an NREG-entry register file and the ALU. Instructions
//   come from an external synchronous ROM with a 1-cycle read latency. Each
//   instruction takes four cycles. The core has run control, a halt state,
//   signed BNE offsets, illegal-opcode detection and a retire strobe.
//
// Instruction fields:
//   op = IR[DATA_W-1 -: 3], rs = IR[DATA_W-4 -: RSEL_W],
//   rt = next RSEL_W bits, fn = IR[1:0]
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   run          in   level; leaves IDLE when high, checked again in WB
//   branch       in   external redirect request, honoured only in FETCH
//   branch_addr  in   external redirect target
//   step         in   (only with CPU_STEP_EN) FETCH waits for step=1
//   imem_addr    out  ROM address (= PC)
//   imem_rdata   in   ROM data, valid the cycle after imem_addr
//   pc_out       out  current PC
//   alu_result   out  registered result of the last EXEC
//   retire       out  1-cycle pulse during WB
//   halted       out  high in HALT
//   illegal      out  sticky flag, set when a reserved opcode retires
//
// Configuration macro: CPU_STEP_EN (adds the step input).

module cpu_core_mc #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 10,
   parameter int NREG   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              branch,
   input  logic [ADDR_W-1:0] branch_addr,
`ifdef CPU_STEP_EN
   input  logic              step,
`endif
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0] pc_out,
   output logic [DATA_W-1:0] alu_result,
   output logic              retire,
   output logic              halted,
   output logic              illegal
);

   localparam int RSEL_W = $clog2(NREG);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
   } state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] pc_reg;
   logic [DATA_W-1:0] ir_reg;
   logic [DATA_W-1:0] regs [NREG];

   logic [2:0]        op;
   logic [RSEL_W-1:0] rs;
   logic [RSEL_W-1:0] rt;
   logic [1:0]        fn;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [DATA_W-1:0] alu_next;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] br_off;
   logic              writes_rt;
   logic              is_halt;
   logic              is_reserved;
   logic              bne_taken;
   logic              step_ok;
   logic              unused_ir_bits;

   assign op     = ir_reg[DATA_W-1 -: 3];
   assign rs     = ir_reg[DATA_W-4 -: RSEL_W];
   assign rt     = ir_reg[DATA_W-4-RSEL_W -: RSEL_W];
   assign fn     = ir_reg[1:0];
   assign rs_val = regs[rs];
   assign rt_val = regs[rt];

   // Any padding bits between rt and fn are ignored.
   assign unused_ir_bits = ^ir_reg;

`ifdef CPU_STEP_EN
   assign step_ok = step;
`else
   assign step_ok = 1'b1;
`endif

   assign writes_rt   = (op == 3'b000) || ((op == 3'b001) && !fn[1]);
   assign is_halt     = (op == 3'b001) && (fn == 2'b10);
   assign is_reserved = op[2] || (op[1] && op[0]);

   // For bne, EXEC stores R[rs]-R[rt]. A nonzero difference means the
   // operands are unequal, so WB can decide the branch from alu_result.
   assign bne_taken = (op == 3'b010) && (alu_result != '0);
   assign br_off    = {{(ADDR_W-2){fn[1]}}, fn};

   always_comb begin
      alu_next = '0;
      case (op)
         3'b000: begin
            case (fn)
               2'b00:   alu_next = rs_val + rt_val;
               2'b01:   alu_next = rs_val - rt_val;
               2'b10:   alu_next = {{(DATA_W-1){1'b0}}, ($signed(rs_val) < $signed(rt_val))};
               default: alu_next = ~(rs_val & rt_val);
            endcase
         end
         3'b001: begin
            if (fn == 2'b00)
               alu_next = rs_val >> rt_val[3:0];
            else if (fn == 2'b01)
               alu_next = rs_val << rt_val[3:0];
         end
         3'b010:  alu_next = rs_val - rt_val;
         default: alu_next = '0;
      endcase
   end

   always_comb begin
      pc_next = pc_reg + ADDR_W'(1);
      if (is_halt)
         pc_next = pc_reg;
      else if (bne_taken)
         pc_next = pc_reg + ADDR_W'(1) + br_off;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         pc_reg     <= '0;
         ir_reg     <= '0;
         alu_result <= '0;
         retire     <= 1'b0;
         halted     <= 1'b0;
         illegal    <= 1'b0;
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else begin
         retire <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (run)
                  state_reg <= S_FETCH;
            end
            S_FETCH: begin
               // A redirect wins over advancing and keeps FETCH, so the
               // next ROM read uses the new PC.
               if (branch)
                  pc_reg <= branch_addr;
               else if (step_ok)
                  state_reg <= S_DECODE;
            end
            S_DECODE: begin
               ir_reg    <= imem_rdata;
               state_reg <= S_EXEC;
            end
            S_EXEC: begin
               alu_result <= alu_next;
               retire     <= 1'b1;   // high during the following WB cycle
               state_reg  <= S_WB;
            end
            S_WB: begin
               if (writes_rt)
                  regs[rt] <= alu_result;
               if (is_reserved)
                  illegal <= 1'b1;
               pc_reg <= pc_next;
               if (is_halt) begin
                  state_reg <= S_HALT;
                  halted    <= 1'b1;
               end else if (run) begin
                  state_reg <= S_FETCH;
               end else begin
                  state_reg <= S_IDLE;
               end
            end
            S_HALT: begin
               // Only reset leaves HALT.
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign imem_addr = pc_reg;
   assign pc_out    = pc_reg;

endmodule

// File: tb/tb_cpu_core_mc.sv
module tb_cpu_core_mc;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic       branch = 1'b0;
   logic [9:0] branch_addr = '0;
   logic [9:0] imem_addr;
   logic [9:0] imem_rdata = '0;
   logic [9:0] pc_out;
   logic [9:0] alu_result;
   logic       retire;
   logic       halted;
   logic       illegal;
`ifdef CPU_STEP_EN
   logic       step = 1'b1;
`endif

   int tests = 0;
   int fails = 0;

   logic [9:0] rom [1024];

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= rom[imem_addr];

   cpu_core_mc dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .branch      (branch),
      .branch_addr (branch_addr),
`ifdef CPU_STEP_EN
      .step        (step),
`endif
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .pc_out      (pc_out),
      .alu_result  (alu_result),
      .retire      (retire),
      .halted      (halted),
      .illegal     (illegal)
   );

   localparam logic [9:0] NOP = 10'b001_00_00_0_11;

   function automatic logic [9:0] enc(input logic [2:0] op, input logic [1:0] rs,
                                      input logic [1:0] rt, input logic [1:0] fn);
      return {op, rs, rt, 1'b0, fn};
   endfunction

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Waits (bounded) for the retire pulse, checks alu_result during WB and
   // the PC one cycle later. Returns at a negedge.
   task automatic exec_check(input string tag, input logic chk_alu,
                             input logic [9:0] exp_alu, input logic [9:0] exp_pc);
      int n = 0;
      while (retire !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_retire"}, {9'b0, retire}, 10'd1);
      if (chk_alu)
         check({tag, "_alu"}, alu_result, exp_alu);
      @(negedge clk);
      check({tag, "_pc"}, pc_out, exp_pc);
      $display("[TB] %s: pc=%h alu=%h", tag, pc_out, alu_result);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 1024; i++) rom[i] = NOP;
   endtask

   logic [9:0] p1_ins [18];
   logic [9:0] p1_alu [18];

   initial begin
      // ---------------- reset / idle ----------------
      clear_rom();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_retire", {9'b0, retire}, 10'd0);
      end
      check("idle_pc", pc_out, 10'h000);
      check("idle_imem_addr", imem_addr, 10'h000);
      check("idle_alu", alu_result, 10'h000);
      check("idle_halted", {9'b0, halted}, 10'd0);
      check("idle_illegal", {9'b0, illegal}, 10'd0);

      // ---------------- program 1: ALU ops ----------------
      p1_ins[0]  = enc(3'b000, 2'd0, 2'd3, 2'b11); p1_alu[0]  = 10'h3FF; // nand -> R3
      p1_ins[1]  = enc(3'b000, 2'd0, 2'd3, 2'b01); p1_alu[1]  = 10'h001; // 0-(-1)
      p1_ins[2]  = enc(3'b000, 2'd3, 2'd1, 2'b00); p1_alu[2]  = 10'h001;
      p1_ins[3]  = enc(3'b000, 2'd3, 2'd1, 2'b00); p1_alu[3]  = 10'h002;
      p1_ins[4]  = enc(3'b000, 2'd3, 2'd1, 2'b00); p1_alu[4]  = 10'h003; // R1=3
      p1_ins[5]  = enc(3'b000, 2'd3, 2'd2, 2'b00); p1_alu[5]  = 10'h001;
      p1_ins[6]  = enc(3'b000, 2'd3, 2'd2, 2'b00); p1_alu[6]  = 10'h002;
      p1_ins[7]  = enc(3'b000, 2'd1, 2'd2, 2'b00); p1_alu[7]  = 10'h005; // R2=5
      p1_ins[8]  = enc(3'b000, 2'd1, 2'd2, 2'b00); p1_alu[8]  = 10'h008; // 3+5
      p1_ins[9]  = enc(3'b000, 2'd1, 2'd2, 2'b01); p1_alu[9]  = 10'h3FB; // 3-8
      p1_ins[10] = enc(3'b000, 2'd2, 2'd3, 2'b10); p1_alu[10] = 10'h001; // -5<1
      p1_ins[11] = enc(3'b000, 2'd3, 2'd2, 2'b10); p1_alu[11] = 10'h000; // 1<-5
      p1_ins[12] = enc(3'b000, 2'd1, 2'd1, 2'b11); p1_alu[12] = 10'h3FC; // ~3
      p1_ins[13] = enc(3'b001, 2'd3, 2'd3, 2'b01); p1_alu[13] = 10'h002; // 1<<1
      p1_ins[14] = enc(3'b001, 2'd3, 2'd3, 2'b01); p1_alu[14] = 10'h008; // 2<<2
      p1_ins[15] = enc(3'b001, 2'd1, 2'd3, 2'b00); p1_alu[15] = 10'h003; // 3FC>>8
      p1_ins[16] = enc(3'b001, 2'd1, 2'd3, 2'b01); p1_alu[16] = 10'h3E0; // 3FC<<3
      p1_ins[17] = enc(3'b001, 2'd1, 2'd3, 2'b00); p1_alu[17] = 10'h3FC; // amt 3E0[3:0]=0
      for (int i = 0; i < 18; i++) rom[i] = p1_ins[i];
      rom[18] = enc(3'b001, 2'd0, 2'd0, 2'b10);                          // halt

      run = 1'b1;
      for (int i = 0; i < 18; i++)
         exec_check($sformatf("p1_i%0d", i), 1'b1, p1_alu[i], 10'(i + 1));
      exec_check("halt", 1'b0, 10'h000, 10'd18);
      check("halt_halted", {9'b0, halted}, 10'd1);
      for (int i = 0; i < 20; i++) begin
         run = i[0];
         branch = ~i[0];
         branch_addr = 10'h055;
         @(negedge clk);
         check("halt_hold_pc", pc_out, 10'd18);
         check("halt_hold_halted", {9'b0, halted}, 10'd1);
         check("halt_hold_retire", {9'b0, retire}, 10'd0);
      end
      branch = 1'b0;
      run = 1'b0;

      // Asynchronous reset away from any clock edge.
      #2 reset = 1'b1;
      #1;
      check("areset_pc", pc_out, 10'h000);
      check("areset_halted", {9'b0, halted}, 10'd0);
      check("areset_alu", alu_result, 10'h000);

      // ---------------- program 2: branches, illegal ----------------
      clear_rom();
      rom[0]      = enc(3'b010, 2'd0, 2'd1, 2'b10); // bne R0,R1,-2
      rom[1]      = enc(3'b000, 2'd0, 2'd3, 2'b11); // nand -> R3=3FF
      rom[2]      = enc(3'b010, 2'd0, 2'd3, 2'b01); // bne +1
      rom[3]      = enc(3'b000, 2'd3, 2'd3, 2'b11); // nand R3,R3 -> 0
      rom[4]      = enc(3'b010, 2'd3, 2'd0, 2'b10); // bne -2
      rom[5]      = enc(3'b000, 2'd0, 2'd2, 2'b11); // R2=3FF
      rom[6]      = enc(3'b011, 2'd0, 2'd2, 2'b01); // reserved
      rom[7]      = enc(3'b000, 2'd2, 2'd1, 2'b00); // R1=R2+R1
      rom[8]      = NOP;
      rom[10'h100] = enc(3'b000, 2'd1, 2'd2, 2'b00); // R2=R1+R2
      @(negedge clk);
      reset = 1'b0;
      run = 1'b1;
      exec_check("bne0_eq", 1'b0, 10'h000, 10'h001);
      exec_check("nand_r3", 1'b1, 10'h3FF, 10'h002);
      exec_check("bne_fwd", 1'b0, 10'h000, 10'h004);
      exec_check("bne_back", 1'b0, 10'h000, 10'h003);
      exec_check("nand_self", 1'b1, 10'h000, 10'h004);
      exec_check("bne_eq", 1'b0, 10'h000, 10'h005);
      exec_check("nand_r2", 1'b1, 10'h3FF, 10'h006);
      check("illegal_before", {9'b0, illegal}, 10'd0);
      exec_check("reserved", 1'b0, 10'h000, 10'h007);
      check("illegal_set", {9'b0, illegal}, 10'd1);
      exec_check("r2_kept", 1'b1, 10'h3FF, 10'h008);
      exec_check("nop", 1'b0, 10'h000, 10'h009);

      branch = 1'b1; branch_addr = 10'h000;
      @(negedge clk);
      branch = 1'b0;
      check("redirect0_pc", pc_out, 10'h000);
      exec_check("bne_wrap", 1'b0, 10'h000, 10'h3FF);
      exec_check("pc_wrap", 1'b0, 10'h000, 10'h000);

      branch = 1'b1; branch_addr = 10'h100;
      @(negedge clk);
      branch = 1'b0;
      check("redirect_imem_addr", imem_addr, 10'h100);
      exec_check("add_at_100", 1'b1, 10'h3FE, 10'h101);

      run = 1'b0;
      exec_check("last_before_idle", 1'b0, 10'h000, 10'h102);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("runlow_retire", {9'b0, retire}, 10'd0);
         check("runlow_pc", pc_out, 10'h102);
      end
      check("illegal_sticky", {9'b0, illegal}, 10'd1);

`ifdef CPU_STEP_EN
      begin
         int retires;
         reset = 1'b1;
         clear_rom();
         step = 1'b0;
         @(negedge clk);
         reset = 1'b0;
         run = 1'b1;
         retires = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (retire === 1'b1) retires++;
         end
         check("step_low_retires", 10'(retires), 10'd0);
         step = 1'b1;
         @(negedge clk);
         step = 1'b0;
         retires = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (retire === 1'b1) retires++;
         end
         check("step_pulse_retires", 10'(retires), 10'd1);
         check("step_pulse_pc", pc_out, 10'h001);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
